axis_row_producer: RTL and testbench
====================================

AXIS_ROW_PRODUCER -- requirements
Module: axis_row_producer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, the per-channel TDATA width in bits; only 512 is supported.
REQ-002 SHALL have parameter CYCLES_PER_ROW, default 16, the number of data cycles per row (2048 bytes / 128 bytes per pair).
REQ-003 SHALL have ports clk input 1 (sole clock) and resetn input 1; resetn is asynchronous, active-low.
REQ-004 SHALL have ports start input 1 (pulse, begins a dataset) and row_count input 32 (rows in the dataset, sampled at start).
REQ-005 SHALL have ports err_inject input 1 (pulse, corrupt one data cycle) and busy output 1.
REQ-006 SHALL have ports done output 1 (one-cycle pulse) and rows_sent output 64.
REQ-007 SHALL have ports AXIS_CH0_TDATA/TKEEP/TVALID/TLAST output 512/64/1/1 and AXIS_CH0_TREADY input 1.
REQ-008 SHALL have ports AXIS_CH1_TDATA/TKEEP/TVALID/TLAST output 512/64/1/1 and AXIS_CH1_TREADY input 1.
REQ-009 SHALL have ports AXI_REQ_TDATA input 72, AXI_REQ_TVALID input 1 and AXI_REQ_TREADY output 1.

Function
REQ-010 SHALL emit a "pair": the same cycle index presented on CH0 and CH1; TKEEP is all ones on both channels.
REQ-011 SHALL deassert each channel's TVALID once that channel handshakes, and SHALL present the next pair only after both channels have handshaken, in either order or together.
REQ-012 SHALL advance a pair with zero bubble when both channels handshake in the same cycle, allowing one pair per clk.
REQ-013 SHALL follow the state machine IDLE -> HDR -> DATA -> TRAIL -> (HDR if rows remain, else IDLE); REQ is entered from IDLE or after TRAIL when AXI_REQ_TVALID=1, then returns to the pending state.
REQ-014 SHALL, in HDR, drive CH1 TDATA[511:504]=8'h02 and TDATA[63:0]=rows_sent, with CH0 all zero.
REQ-015 SHALL, in DATA, drive both channels with 16 32-bit words built from seed s: word k = s, s^FFFFFFFF, s^AAAAAAAA, s^55555555 repeating (k mod 4).
REQ-016 SHALL start seed s at 0 per dataset and increment it per data pair, wrapping modulo 2^32.
REQ-017 SHALL, in TRAIL, drive CH1 TDATA[511:504]=8'h03 with TLAST=1 on both channels; TLAST=0 on all other pairs.
REQ-018 SHALL, in REQ, assert AXI_REQ_TREADY for exactly one cycle to pop one request.
REQ-019 SHALL send the popped request as a one-pair packet: CH1 TDATA[511:504]=8'h01, TDATA[64:0]=request[64:0], TLAST=1.
REQ-020 SHALL never insert request packets inside a row.
REQ-021 SHALL increment rows_sent when a TRAIL pair completes, and SHALL clear it on start.
REQ-022 SHALL hold busy=1 from the cycle after start until return to IDLE, and SHALL pulse done for one cycle on the final trailer completion.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL, when start arrives with row_count=0, pulse done on the next cycle and send no rows.
REQ-025 SHALL count CYCLES_PER_ROW data pairs per row exactly, regardless of backpressure.

Reset
REQ-026 SHALL, with resetn=0, immediately force state=IDLE, all TVALID=0, TLAST=0, AXI_REQ_TREADY=0, busy=0, done=0, rows_sent=0, seed=0.
REQ-027 SHALL, on reset mid-row, abandon the partial row; no resume after release.

Configuration
REQ-028 SHALL, when macro ROW_PRODUCER_ERR_INJECT_EN is defined, XOR 32'h1 into CH1 word 1 of the next data pair after an err_inject pulse, corrupting exactly one pair.
REQ-029 SHALL, without ROW_PRODUCER_ERR_INJECT_EN, ignore err_inject entirely.

Structure
REQ-030 SHALL place packet-type constants (01 request, 02 header, 03 trailer), the pattern XOR masks and the state enum in shared package row_pkt_pkg.
REQ-031 SHALL implement the pair handshake (per-channel valid and pair-complete) in sub-module axis_pair_tx.

Verification
REQ-032 SHALL verify: start, row_count=1, both TREADY=1 -> 18 pairs in 18 cycles, first data word 0, done pulse, rows_sent=1.
REQ-033 SHALL verify: row_count=3, CH1 TREADY toggling 50% -> 54 pairs, data identical, seeds 0..47 in order.
REQ-034 SHALL verify: AXI_REQ_TVALID with 72'h0_12345678_00001000 during row 0 of 2 -> request packet between trailer 0 and header 1, [64:0] matching.
REQ-035 SHALL verify: row_count=0 -> done one cycle after start, no TVALID.
REQ-036 SHALL verify: resetn low at data pair 7 -> TVALID drops immediately, rows_sent=0, fresh start resends seed 0.
REQ-037 SHALL verify: with ROW_PRODUCER_ERR_INJECT_EN, err_inject in DATA -> one pair's CH1 word 1 off by 1, subsequent pairs clean.

Source files
------------

// File: rtl/row_pkt_pkg.sv
// Shared packet constants, pattern masks, FSM state and pair payload for the row producer.
package row_pkt_pkg;

  localparam int unsigned DATA_W = 512;
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned WORDS  = DATA_W / 32;
  localparam int unsigned REQ_W  = 72;

  localparam logic [7:0] PKT_REQ = 8'h01;
  localparam logic [7:0] PKT_HDR = 8'h02;
  localparam logic [7:0] PKT_TRL = 8'h03;

  // Word k of a data pair is seed ^ PAT_MASK[k mod 4]
  localparam logic [3:0][31:0] PAT_MASK = {32'h5555_5555, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h0000_0000};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_TRAIL,
    ST_REQ
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic              last;
  } pair_t;

  function automatic pair_t hdr_pair(input logic [63:0] n);
    pair_t p;
    p = '0;
    p.d1[DATA_W-1 -: 8] = PKT_HDR;
    p.d1[63:0]          = n;
    return p;
  endfunction

  function automatic pair_t trl_pair();
    pair_t p;
    p = '0;
    p.d1[DATA_W-1 -: 8] = PKT_TRL;
    p.last              = 1'b1;
    return p;
  endfunction

  function automatic pair_t req_pair(input logic [64:0] r);
    pair_t p;
    p = '0;
    p.d1[DATA_W-1 -: 8] = PKT_REQ;
    p.d1[64:0]          = r;
    p.last              = 1'b1;
    return p;
  endfunction

  function automatic pair_t data_pair(input logic [31:0] s, input logic err);
    pair_t             p;
    logic [DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < int'(WORDS); k++) begin
      w[32*k +: 32] = s ^ PAT_MASK[2'(k)];
    end
    p.d0   = w;
    p.d1   = w;
    p.last = 1'b0;
    if (err) p.d1[63:32] = w[63:32] ^ 32'h1;
    return p;
  endfunction

endpackage

// File: rtl/axis_row_producer_if.sv
// One AXI-Stream output channel of the row producer.
interface axis_row_producer_if;
  logic [row_pkt_pkg::DATA_W-1:0] tdata;
  logic [row_pkt_pkg::KEEP_W-1:0] tkeep;
  logic                           tvalid;
  logic                           tlast;
  logic                           tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_pair_tx.sv
// Presents one pair on two AXIS channels; each valid drops on its own handshake.
module axis_pair_tx
  import row_pkt_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  logic  load,
  input  pair_t pay,
  output logic  free_c,
  output logic  pair_done_c,
  axis_row_producer_if.master ch0,
  axis_row_producer_if.master ch1
);

  logic              v0_q, v1_q, last_q;
  logic [DATA_W-1:0] d0_q, d1_q;

  // Pair completes on the cycle the last outstanding channel handshakes
  assign pair_done_c = (v0_q | v1_q) & (~v0_q | ch0.tready) & (~v1_q | ch1.tready);
  assign free_c      = ~(v0_q | v1_q) | pair_done_c;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      last_q <= 1'b0;
      d0_q   <= '0;
      d1_q   <= '0;
    end else if (load) begin
      v0_q   <= 1'b1;
      v1_q   <= 1'b1;
      last_q <= pay.last;
      d0_q   <= pay.d0;
      d1_q   <= pay.d1;
    end else begin
      if (ch0.tready) v0_q <= 1'b0;
      if (ch1.tready) v1_q <= 1'b0;
    end
  end

  assign ch0.tdata  = d0_q;
  assign ch0.tkeep  = '1;
  assign ch0.tvalid = v0_q;
  assign ch0.tlast  = last_q;
  assign ch1.tdata  = d1_q;
  assign ch1.tkeep  = '1;
  assign ch1.tvalid = v1_q;
  assign ch1.tlast  = last_q;

endmodule

// File: rtl/axis_row_producer.sv
// Streams header/data/trailer rows on two paired AXIS channels, interleaving popped requests between rows.
// Optional ROW_PRODUCER_ERR_INJECT_EN: err_inject corrupts CH1 word 1 of the next data pair.
module axis_row_producer
  import row_pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned CYCLES_PER_ROW = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [31:0]             row_count,
  input  logic                    err_inject,
  output logic                    busy,
  output logic                    done,
  output logic [63:0]             rows_sent,
  output logic [DATA_WIDTH-1:0]   AXIS_CH0_TDATA,
  output logic [DATA_WIDTH/8-1:0] AXIS_CH0_TKEEP,
  output logic                    AXIS_CH0_TVALID,
  output logic                    AXIS_CH0_TLAST,
  input  logic                    AXIS_CH0_TREADY,
  output logic [DATA_WIDTH-1:0]   AXIS_CH1_TDATA,
  output logic [DATA_WIDTH/8-1:0] AXIS_CH1_TKEEP,
  output logic                    AXIS_CH1_TVALID,
  output logic                    AXIS_CH1_TLAST,
  input  logic                    AXIS_CH1_TREADY,
  input  logic [REQ_W-1:0]        AXI_REQ_TDATA,
  input  logic                    AXI_REQ_TVALID,
  output logic                    AXI_REQ_TREADY
);

  localparam int unsigned CNT_W = $clog2(CYCLES_PER_ROW) + 1;

  state_t           state_q, pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      seed_q, row_count_q;
  logic             trail_loaded_q;
  logic             free_c, pair_done_c, load_c, more_c, err_c;
  pair_t            pay_c;
  logic [6:0]       unused_req_hi;

  axis_row_producer_if ch0_if ();
  axis_row_producer_if ch1_if ();

  assign unused_req_hi   = AXI_REQ_TDATA[REQ_W-1:65];
  assign AXIS_CH0_TDATA  = ch0_if.tdata;
  assign AXIS_CH0_TKEEP  = ch0_if.tkeep;
  assign AXIS_CH0_TVALID = ch0_if.tvalid;
  assign AXIS_CH0_TLAST  = ch0_if.tlast;
  assign ch0_if.tready   = AXIS_CH0_TREADY;
  assign AXIS_CH1_TDATA  = ch1_if.tdata;
  assign AXIS_CH1_TKEEP  = ch1_if.tkeep;
  assign AXIS_CH1_TVALID = ch1_if.tvalid;
  assign AXIS_CH1_TLAST  = ch1_if.tlast;
  assign ch1_if.tready   = AXIS_CH1_TREADY;

  axis_pair_tx u_pair_tx (
    .clk         (clk),
    .resetn      (resetn),
    .load        (load_c),
    .pay         (pay_c),
    .free_c      (free_c),
    .pair_done_c (pair_done_c),
    .ch0         (ch0_if),
    .ch1         (ch1_if)
  );

`ifdef ROW_PRODUCER_ERR_INJECT_EN
  logic err_pend_q;

  assign err_c = err_pend_q | err_inject;

  // Armed by a pulse, consumed by the next data pair loaded
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                           err_pend_q <= 1'b0;
    else if (state_q == ST_DATA && free_c) err_pend_q <= 1'b0;
    else if (err_inject)                   err_pend_q <= 1'b1;
  end
`else
  logic unused_err;
  assign unused_err = err_inject;
  assign err_c      = 1'b0;
`endif

  assign more_c = (rows_sent + 64'd1) < {32'd0, row_count_q};

  // Pair selection; a header following a trailer loads on the trailer's completing cycle
  always_comb begin
    load_c = 1'b0;
    pay_c  = '0;
    case (state_q)
      ST_HDR: begin
        if (free_c) begin
          load_c = 1'b1;
          pay_c  = hdr_pair(rows_sent);
        end
      end
      ST_DATA: begin
        if (free_c) begin
          load_c = 1'b1;
          pay_c  = data_pair(seed_q, err_c);
        end
      end
      ST_TRAIL: begin
        if (!trail_loaded_q && free_c) begin
          load_c = 1'b1;
          pay_c  = trl_pair();
        end else if (trail_loaded_q && pair_done_c && !AXI_REQ_TVALID && more_c) begin
          load_c = 1'b1;
          pay_c  = hdr_pair(rows_sent + 64'd1);
        end
      end
      ST_REQ: begin
        load_c = 1'b1;
        pay_c  = req_pair(AXI_REQ_TDATA[64:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      pend_q         <= ST_IDLE;
      cnt_q          <= '0;
      seed_q         <= '0;
      row_count_q    <= '0;
      trail_loaded_q <= 1'b0;
      rows_sent      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      AXI_REQ_TREADY <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rows_sent   <= '0;
            seed_q      <= '0;
            row_count_q <= row_count;
            if (row_count == 32'd0) begin
              done <= 1'b1;
            end else begin
              state_q <= ST_HDR;
              busy    <= 1'b1;
            end
          end else if (AXI_REQ_TVALID && free_c) begin
            state_q        <= ST_REQ;
            pend_q         <= ST_IDLE;
            AXI_REQ_TREADY <= 1'b1;
          end
        end
        ST_HDR: begin
          if (free_c) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
          end
        end
        ST_DATA: begin
          if (free_c) begin
            seed_q <= seed_q + 32'd1;
            if (cnt_q == CNT_W'(CYCLES_PER_ROW - 1)) begin
              state_q        <= ST_TRAIL;
              trail_loaded_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_TRAIL: begin
          if (!trail_loaded_q && free_c) begin
            trail_loaded_q <= 1'b1;
          end else if (trail_loaded_q && pair_done_c) begin
            rows_sent      <= rows_sent + 64'd1;
            trail_loaded_q <= 1'b0;
            if (!more_c) done <= 1'b1;
            if (AXI_REQ_TVALID) begin
              state_q        <= ST_REQ;
              pend_q         <= more_c ? ST_HDR : ST_IDLE;
              AXI_REQ_TREADY <= 1'b1;
            end else if (more_c) begin
              state_q <= ST_DATA;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        ST_REQ: begin
          AXI_REQ_TREADY <= 1'b0;
          state_q        <= pend_q;
          if (pend_q == ST_IDLE) busy <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_row_producer.sv
// Directed self-checking bench for axis_row_producer.
module tb_axis_row_producer;

  typedef struct packed {
    logic [511:0] d;
    logic         last;
  } beat_t;

  typedef struct packed {
    logic [511:0] d0;
    logic [511:0] d1;
    logic         last;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] row_count = '0;
  logic        err_inject = 1'b0;
  logic [71:0] req_tdata = '0;
  logic        req_tvalid = 1'b0;
  logic        req_tready;
  logic        busy, done;
  logic [63:0] rows_sent;
  bit          tog = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int rq_cnt = 0;

  beat_t q0[$];
  beat_t q1[$];
  int    c0[$];
  exp_t  eq[$];

`ifdef ROW_PRODUCER_ERR_INJECT_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  axis_row_producer_if ch0 ();
  axis_row_producer_if ch1 ();

  always #5 clk = ~clk;

  axis_row_producer dut (
    .clk             (clk),
    .resetn          (resetn),
    .start           (start),
    .row_count       (row_count),
    .err_inject      (err_inject),
    .busy            (busy),
    .done            (done),
    .rows_sent       (rows_sent),
    .AXIS_CH0_TDATA  (ch0.tdata),
    .AXIS_CH0_TKEEP  (ch0.tkeep),
    .AXIS_CH0_TVALID (ch0.tvalid),
    .AXIS_CH0_TLAST  (ch0.tlast),
    .AXIS_CH0_TREADY (ch0.tready),
    .AXIS_CH1_TDATA  (ch1.tdata),
    .AXIS_CH1_TKEEP  (ch1.tkeep),
    .AXIS_CH1_TVALID (ch1.tvalid),
    .AXIS_CH1_TLAST  (ch1.tlast),
    .AXIS_CH1_TREADY (ch1.tready),
    .AXI_REQ_TDATA   (req_tdata),
    .AXI_REQ_TVALID  (req_tvalid),
    .AXI_REQ_TREADY  (req_tready)
  );

  // Handshake capture between clock edges
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ch0.tvalid && ch0.tready) begin
      q0.push_back(beat_t'({ch0.tdata, ch0.tlast}));
      c0.push_back(cyc);
    end
    if (ch1.tvalid && ch1.tready) q1.push_back(beat_t'({ch1.tdata, ch1.tlast}));
    if (ch0.tvalid || ch1.tvalid) vld_cnt <= vld_cnt + 1;
    if (req_tready) rq_cnt <= rq_cnt + 1;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog) ch1.tready = ~ch1.tready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [31:0] s);
    logic [511:0] w;
    logic [31:0]  m;
    w = '0;
    for (int k = 0; k < 16; k++) begin
      case (k % 4)
        0:       m = 32'h0000_0000;
        1:       m = 32'hFFFF_FFFF;
        2:       m = 32'hAAAA_AAAA;
        default: m = 32'h5555_5555;
      endcase
      w[k*32 +: 32] = s ^ m;
    end
    return w;
  endfunction

  function automatic exp_t mk(input logic [511:0] d0, input logic [511:0] d1, input logic last);
    exp_t e;
    e.d0   = d0;
    e.d1   = d1;
    e.last = last;
    return e;
  endfunction

  task automatic add_row(input logic [63:0] r);
    logic [511:0] h, t;
    h = '0;
    h[511:504] = 8'h02;
    h[63:0]    = r;
    t = '0;
    t[511:504] = 8'h03;
    eq.push_back(mk('0, h, 1'b0));
    for (int k = 0; k < 16; k++) eq.push_back(mk(pat(32'(r) * 32'd16 + 32'(k)), pat(32'(r) * 32'd16 + 32'(k)), 1'b0));
    eq.push_back(mk('0, t, 1'b1));
  endtask

  task automatic clear_all();
    q0.delete();
    q1.delete();
    c0.delete();
    eq.delete();
  endtask

  task automatic pulse_start(input logic [31:0] n);
    @(posedge clk);
    #1;
    start     = 1'b1;
    row_count = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    bit got;
    got = 1'b0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk(tag, 512'(got), 512'(1'b1));
  endtask

  task automatic check_stream(input string tag, input int exp_err);
    int           ec;
    logic [511:0] wbit;
    ec   = 0;
    wbit = 512'h1 << 32;
    chk({tag, "_n0"}, 512'(q0.size()), 512'(eq.size()));
    chk({tag, "_n1"}, 512'(q1.size()), 512'(eq.size()));
    for (int i = 0; i < eq.size(); i++) begin
      if (i < q0.size()) begin
        chk($sformatf("%s_d0_%0d", tag, i), q0[i].d, eq[i].d0);
        chk($sformatf("%s_l0_%0d", tag, i), 512'(q0[i].last), 512'(eq[i].last));
      end
      if (i < q1.size()) begin
        if ((q1[i].d ^ eq[i].d1) == wbit) ec++;
        else chk($sformatf("%s_d1_%0d", tag, i), q1[i].d, eq[i].d1);
        chk($sformatf("%s_l1_%0d", tag, i), 512'(q1[i].last), 512'(eq[i].last));
      end
    end
    chk({tag, "_corrupt"}, 512'(ec), 512'(exp_err));
  endtask

  initial begin
    logic [511:0] rq;
    int           base, span;
    bit           got;
    ch0.tready = 1'b1;
    ch1.tready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_v0", 512'(ch0.tvalid), 512'(1'b0));
    chk("rst_v1", 512'(ch1.tvalid), 512'(1'b0));
    chk("rst_last", 512'({ch0.tlast, ch1.tlast}), 512'(2'b00));
    chk("rst_busy", 512'(busy), 512'(1'b0));
    chk("rst_done", 512'(done), 512'(1'b0));
    chk("rst_rows", 512'(rows_sent), 512'(64'd0));
    chk("rst_rqrdy", 512'(req_tready), 512'(1'b0));
    chk("keep", 512'({ch1.tkeep, ch0.tkeep}), 512'({128{1'b1}}));
    @(posedge clk);
    #1 resetn = 1'b1;

    // One row, no backpressure
    clear_all();
    pulse_start(32'd1);
    @(negedge clk);
    chk("t1_busy", 512'(busy), 512'(1'b1));
    wait_done("t1_done", 80);
    chk("t1_rows", 512'(rows_sent), 512'(64'd1));
    @(negedge clk);
    chk("t1_done_pulse", 512'(done), 512'(1'b0));
    chk("t1_idle", 512'(busy), 512'(1'b0));
    add_row(64'd0);
    check_stream("t1", 0);
    span = (c0.size() > 0) ? (c0[c0.size()-1] - c0[0] + 1) : 0;
    chk("t1_span", 512'(span), 512'(18));

    // Three rows, CH1 ready toggling
    clear_all();
    ch1.tready = 1'b0;
    tog = 1'b1;
    pulse_start(32'd3);
    wait_done("t2_done", 400);
    tog = 1'b0;
    ch1.tready = 1'b1;
    chk("t2_rows", 512'(rows_sent), 512'(64'd3));
    for (int r = 0; r < 3; r++) add_row(64'(r));
    check_stream("t2", 0);

    // Request arriving during row 0 of 2
    clear_all();
    #1 base = rq_cnt;
    pulse_start(32'd2);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    req_tdata  = 72'h0_12345678_00001000;
    req_tvalid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (req_tready) got = 1'b1;
    end
    chk("t3_pop", 512'(got), 512'(1'b1));
    @(posedge clk);
    #1 req_tvalid = 1'b0;
    wait_done("t3_done", 200);
    @(negedge clk);
    #1;
    chk("t3_rdy_cycles", 512'(rq_cnt - base), 512'(1));
    add_row(64'd0);
    rq = '0;
    rq[511:504] = 8'h01;
    rq[64:0]    = 65'h0_12345678_00001000;
    eq.push_back(mk('0, rq, 1'b1));
    add_row(64'd1);
    check_stream("t3", 0);

    // Zero-row dataset
    clear_all();
    #1 base = vld_cnt;
    pulse_start(32'd0);
    @(negedge clk);
    chk("t4_done", 512'(done), 512'(1'b1));
    chk("t4_busy", 512'(busy), 512'(1'b0));
    @(negedge clk);
    chk("t4_done_pulse", 512'(done), 512'(1'b0));
    repeat (4) @(negedge clk);
    #1;
    chk("t4_no_valid", 512'(vld_cnt - base), 512'(0));
    chk("t4_rows", 512'(rows_sent), 512'(64'd0));

    // Reset mid-row, then a fresh dataset with one err_inject pulse
    clear_all();
    pulse_start(32'd1);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      #1;
      if (q0.size() >= 8) got = 1'b1;
    end
    chk("t5_reach", 512'(got), 512'(1'b1));
    resetn = 1'b0;
    #1;
    chk("t5_v0", 512'(ch0.tvalid), 512'(1'b0));
    chk("t5_v1", 512'(ch1.tvalid), 512'(1'b0));
    chk("t5_rows", 512'(rows_sent), 512'(64'd0));
    chk("t5_busy", 512'(busy), 512'(1'b0));
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("t5_no_resume", 512'(ch0.tvalid | ch1.tvalid), 512'(1'b0));
    clear_all();
    pulse_start(32'd1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 err_inject = 1'b1;
    @(posedge clk);
    #1 err_inject = 1'b0;
    wait_done("t5_done", 80);
    chk("t5_rows_after", 512'(rows_sent), 512'(64'd1));
    add_row(64'd0);
    check_stream("t5", ERR_EXP);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
